mpu_matrix_loader: RTL and testbench

MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

---
 rtl/mpu_pkg.sv | 16 +
 rtl/mpu_matrix_loader.sv | 115 +++++++++++
 tb/tb_mpu_matrix_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU pipeline stages: element geometry and the
// loader state encoding.
package mpu_pkg;

   localparam int unsigned ELEM_W   = 8;
   localparam int unsigned DIM      = 5;
   localparam int unsigned N        = DIM * DIM;
   localparam int unsigned MATRIX_W = ELEM_W * N;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      FULL = 2'd1,
      DROP = 2'd2
   } mpu_state_e;

endpackage

// File: rtl/mpu_matrix_loader.sv
// Matrix loader: assembles a DIM x DIM matrix of signed elements from a
// valid/ready element stream framed by in_last, holds it until the
// downstream stage takes it, and flags frames of the wrong length.
module mpu_matrix_loader
   import mpu_pkg::*;
#(
   parameter int unsigned ELEM_W = mpu_pkg::ELEM_W,
   parameter int unsigned DIM    = mpu_pkg::DIM
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ELEM_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         matrix_valid,
   input  logic                         matrix_ready,
   output logic [ELEM_W*DIM*DIM-1:0]    matrix,
   output logic                         frame_error
);

   localparam int unsigned NUM_EL = DIM * DIM;
   localparam int unsigned MAT_W  = ELEM_W * NUM_EL;
   localparam int unsigned CNT_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_EL - 1);

   mpu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [MAT_W-1:0]  matrix_q, matrix_d;
   logic              frame_error_q, frame_error_d;
   logic              accept;

   assign accept = in_valid && in_ready;

   // State, slot counter, matrix storage and error pulse registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= LOAD;
         count_q       <= '0;
         matrix_q      <= '0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         matrix_q      <= matrix_d;
         frame_error_q <= frame_error_d;
      end
   end

   // Next state, slot counter and frame-length error detection.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      frame_error_d = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (accept) begin
               if (count_q == LAST_IDX) begin
                  count_d = '0;
                  if (in_last) begin
                     state_d = FULL;
                  end else begin
                     // Frame overran the matrix: discard the rest up to in_last.
                     frame_error_d = 1'b1;
                     state_d       = DROP;
                  end
               end else if (in_last) begin
                  frame_error_d = 1'b1;
                  count_d       = '0;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (matrix_ready) begin
               state_d = LOAD;
               count_d = '0;
            end
         end
         DROP: begin
            if (accept && in_last) begin
               state_d = LOAD;
               count_d = '0;
            end
         end
         default: begin
            state_d = LOAD;
            count_d = '0;
         end
      endcase
   end

   // Slot write: only elements accepted while loading land in the matrix.
   always_comb begin
      matrix_d = matrix_q;
      if (state_q == LOAD && accept) begin
         for (int unsigned k = 0; k < NUM_EL; k++) begin
            if (count_q == CNT_W'(k)) begin
               matrix_d[k*ELEM_W +: ELEM_W] = in_data;
            end
         end
      end
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      in_ready     = (state_q != FULL) && !reset;
      matrix_valid = (state_q == FULL);
   end

   assign matrix      = matrix_q;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: table of per-cycle vectors plus
// hand-written sequences for overrun, back-pressure and reset corner cases.
module tb_mpu_matrix_loader;

   localparam int unsigned EW = 8;
   localparam int unsigned DM = 5;
   localparam int unsigned NE = DM * DM;

   logic              clock = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [EW-1:0]     in_data;
   logic              in_last;
   logic              matrix_valid;
   logic              matrix_ready;
   logic [EW*NE-1:0]  matrix;
   logic              frame_error;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic          valid;
      logic [EW-1:0] data;
      logic          last;
      logic          mready;
      logic          exp_ir;
      logic          exp_mv;
      logic          exp_fe;
   } vec_t;

   vec_t tbl[40];

   mpu_matrix_loader #(.ELEM_W(EW), .DIM(DM)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .matrix_valid (matrix_valid),
      .matrix_ready (matrix_ready),
      .matrix       (matrix),
      .frame_error  (frame_error)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic v, input logic [EW-1:0] d, input logic l,
                               input logic mr, input logic ir, input logic mv,
                               input logic fe);
      vec_t r;
      r.valid = v; r.data = d; r.last = l; r.mready = mr;
      r.exp_ir = ir; r.exp_mv = mv; r.exp_fe = fe;
      return r;
   endfunction

   function automatic logic [EW-1:0] slot(input int k);
      return matrix[k*EW +: EW];
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [EW-1:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int base);
      for (int i = 0; i < 25; i++) begin
         send(EW'(base + i), (i == 24));
      end
   endtask

   initial begin
      logic [EW*NE-1:0] exp_mat;
      int n;

      // Table: malformed 10-element frame, then a good 1..25 frame held
      // under back-pressure, then handoff with the one-cycle bubble.
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tbl[n] = mk(1'b1, EW'(100 + i), (i == 9), 1'b0, 1'b1, 1'b0, (i == 9));
         n++;
      end
      for (int i = 0; i < 25; i++) begin
         if (i == 24) tbl[n] = mk(1'b1, EW'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         else         tbl[n] = mk(1'b1, EW'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         tbl[n] = mk(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         n++;
      end
      tbl[n] = mk(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); n++;
      tbl[n] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); n++;

      for (int k = 0; k < NE; k++) exp_mat[k*EW +: EW] = EW'(k + 1);

      // Reset state
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; matrix_ready = 1'b0;
      step(); step();
      chk("rst_matrix_valid", 32'(matrix_valid), 32'd0);
      chk("rst_frame_error",  32'(frame_error),  32'd0);
      chk("rst_matrix_zero",  32'(matrix == '0), 32'd1);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Table-driven vectors
      for (int i = 0; i < n; i++) begin
         in_valid     = tbl[i].valid;
         in_data      = tbl[i].data;
         in_last      = tbl[i].last;
         matrix_ready = tbl[i].mready;
         step();
         chk($sformatf("tbl%0d_in_ready", i),     32'(in_ready),     32'(tbl[i].exp_ir));
         chk($sformatf("tbl%0d_matrix_valid", i), 32'(matrix_valid), 32'(tbl[i].exp_mv));
         chk($sformatf("tbl%0d_frame_error", i),  32'(frame_error),  32'(tbl[i].exp_fe));
      end
      in_valid = 1'b0; in_last = 1'b0; matrix_ready = 1'b0;
      chk("tbl_matrix_after_handoff", 32'(matrix == exp_mat), 32'd1);

      // Contents persist after handoff, overwritten slot by slot
      send(8'h33, 1'b0);
      chk("persist_slot0", 32'(slot(0)), 32'h33);
      chk("persist_slot1", 32'(slot(1)), 32'h02);
      send(8'h44, 1'b1);
      chk("short_frame_fe", 32'(frame_error), 32'd1);
      step();
      chk("fe_one_cycle", 32'(frame_error), 32'd0);

      // Overrun: 25 elements without in_last, 3 dropped, then good frame
      for (int i = 0; i < 24; i++) send(EW'(50 + i), 1'b0);
      send(EW'(74), 1'b0);
      chk("overrun_fe", 32'(frame_error), 32'd1);
      chk("overrun_mv", 32'(matrix_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         send(8'hA0 + EW'(i), (i == 2));
         chk($sformatf("drop%0d_mv", i), 32'(matrix_valid), 32'd0);
         chk($sformatf("drop%0d_ir", i), 32'(in_ready), 32'd1);
      end
      chk("drop_slot0_kept",  32'(slot(0)),  32'd50);
      chk("drop_slot24_kept", 32'(slot(24)), 32'd74);
      matrix_ready = 1'b1;
      send_frame(1);
      chk("good_mv", 32'(matrix_valid), 32'd1);
      chk("good_fe", 32'(frame_error), 32'd0);
      chk("good_slot0", 32'(slot(0)), 32'd1);
      chk("good_slot24", 32'(slot(24)), 32'd25);
      chk("scaled_slot24", 32'(2 * $signed(slot(24))), 32'd50);
      step();
      chk("handoff_mv", 32'(matrix_valid), 32'd0);
      chk("handoff_ir", 32'(in_ready), 32'd1);

      // Back-pressure: held 10 cycles with in_valid high
      matrix_ready = 1'b0;
      send_frame(1);
      in_valid = 1'b1; in_data = 8'h5A;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("hold%0d_ir", c), 32'(in_ready), 32'd0);
         chk($sformatf("hold%0d_mv", c), 32'(matrix_valid), 32'd1);
         chk($sformatf("hold%0d_mat", c), 32'(matrix == exp_mat), 32'd1);
      end
      in_valid = 1'b0;
      matrix_ready = 1'b1;
      step();
      matrix_ready = 1'b0;
      chk("release_mv", 32'(matrix_valid), 32'd0);

      // Reset mid-frame, then extreme signed values
      for (int i = 0; i < 12; i++) send(EW'(9 + i), 1'b0);
      reset = 1'b1;
      #1;
      chk("midrst_matrix_zero", 32'(matrix == '0), 32'd1);
      chk("midrst_mv", 32'(matrix_valid), 32'd0);
      in_valid = 1'b1; in_data = 8'h55;
      step(); step();
      chk("rst_no_accept", 32'(matrix == '0), 32'd1);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("post_rst_ir", 32'(in_ready), 32'd1);
      send(8'h80, 1'b0);
      send(8'h7F, 1'b0);
      chk("neg_slot0", 32'(slot(0)), 32'h80);
      chk("pos_slot1", 32'(slot(1)), 32'h7F);
      chk("slot2_zero", 32'(slot(2)), 32'h00);
      chk("upper_zero", 32'(matrix[EW*NE-1:2*EW] == '0), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
